// File: rtl/instruction_fetch_if.sv
// Fetch-unit signal bundle: memory read channel plus the core-side issue/completion handshake.
interface instruction_fetch_if;
  logic [15:0] MEM_ADDR;
  logic        MEM_RD;
  logic        MEM_ACK;
  logic [15:0] MEM_DIN;
  logic [15:0] DOUT;
  logic        EXECUTE;
  logic        DONE;
  logic        PC_LOAD;
  logic [15:0] PC_NEXT;
  logic        DEBUG_MODE;
  logic        DEBUG_STEP;
  logic [15:0] PC;
  logic        BUSY;

  // Fetch unit side
  modport master (
    output MEM_ADDR, MEM_RD, DOUT, EXECUTE, PC, BUSY,
    input  MEM_ACK, MEM_DIN, DONE, PC_LOAD, PC_NEXT, DEBUG_MODE, DEBUG_STEP
  );

  // Memory / core / debugger side
  modport slave (
    input  MEM_ADDR, MEM_RD, DOUT, EXECUTE, PC, BUSY,
    output MEM_ACK, MEM_DIN, DONE, PC_LOAD, PC_NEXT, DEBUG_MODE, DEBUG_STEP
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads one word at PC, issues it to the core with a one-cycle
// EXECUTE strobe, waits for completion, optionally redirects PC, and supports single-step.
module instruction_fetch (
  input  logic                       CLK,
  input  logic                       RESET,
  instruction_fetch_if.master        bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWaitDone,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] dout_q, dout_d;
  logic        step_q;
  logic        step_edge;
  logic        mem_rd;
  logic        execute;

  // Only a fresh 0->1 on DEBUG_STEP counts; a held step releases a single fetch.
  assign step_edge = bus.DEBUG_STEP & ~step_q;

  // Next-state, PC and instruction register update; strobes decoded from current state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dout_d  = dout_q;
    mem_rd  = 1'b0;
    execute = 1'b0;
    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        mem_rd = 1'b1;
        if (bus.MEM_ACK) begin
          dout_d  = bus.MEM_DIN;
          pc_d    = pc_q + 16'd1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        execute = 1'b1;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (bus.DONE) begin
          // Branch target overrides the increment taken at fetch time.
          if (bus.PC_LOAD) begin
            pc_d = bus.PC_NEXT;
          end
          state_d = bus.DEBUG_MODE ? StHold : StFetch;
        end
      end
      StHold: begin
        if (step_edge || !bus.DEBUG_MODE) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, PC, instruction word and step-edge registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      pc_q    <= 16'h0000;
      dout_q  <= 16'h0000;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dout_q  <= dout_d;
      step_q  <= bus.DEBUG_STEP;
    end
  end

  // Strobes come straight from state so reset removes MEM_RD without waiting for a clock.
  assign bus.MEM_RD   = mem_rd;
  assign bus.EXECUTE  = execute;
  assign bus.MEM_ADDR = pc_q;
  assign bus.PC       = pc_q;
  assign bus.DOUT     = dout_q;
  assign bus.BUSY     = (state_q != StIdle) && (state_q != StHold);

endmodule
